mod_neuron_acc: RTL and testbench
=================================

MOD_NEURON_ACC -- requirements
Module: mod_neuron_acc

Interface
REQ-001 Parameter ACC_W, default 40, accumulator width in bits (signed, Q(ACC_W-24).24).
REQ-002 Parameter FRAC_BITS, default 24, product/accumulator fractional bits; fixed at 24 for Q4.12 x Q4.12 operands.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inValid  input  1  term present on inWeight/inAct/inLast.
REQ-006 inReady  output  1  block accepts a term this cycle.
REQ-007 inWeight  input  16  signed Q4.12 weight.
REQ-008 inAct  input  16  signed Q4.12 activation.
REQ-009 inLast  input  1  marks final term of the current neuron sum.
REQ-010 outValid  output  1  outVal holds a completed FP16 sum.
REQ-011 outReady  input  1  downstream activation stage consumes outVal.
REQ-012 outVal  output  16  IEEE half-precision sum {sign, exp[14:10], mant[9:0]}, fed directly to the tanh stage.

Function
REQ-013 A term SHALL be accepted only on a cycle with inValid=1 and inReady=1.
REQ-014 inReady SHALL be 1 in states IDLE and ACCUM and 0 in DRAIN, CONV and OUT.
REQ-015 Accepted terms SHALL be multiplied signed 16x16 into a 32-bit Q8.24 product register (one-cycle stage).
REQ-016 Registered products SHALL be added to a sign-extended ACC_W accumulator; the add SHALL saturate to +/-(2^(ACC_W-1)-1).
REQ-017 States: IDLE (accumulator zero) -> ACCUM on first accepted term; ACCUM -> DRAIN when the accepted term has inLast=1; DRAIN -> CONV once the last product is accumulated; CONV -> OUT after one cycle; OUT -> IDLE on outValid&outReady.
REQ-018 A single term with inLast=1 accepted in IDLE SHALL be a valid one-term sum.
REQ-019 Latency: last term accepted in cycle t -> outValid=1 in cycle t+3.
REQ-020 Conversion: p = MSB index of |acc|; exp = p - 9; mantissa = the 10 bits of |acc| directly below p, truncated toward zero; sign = accumulator sign.
REQ-021 acc = 0, or exp <= 0, SHALL produce 0x0000; denormals are flushed.
REQ-022 exp >= 31 SHALL produce {sign, 15'h7bff}; this is unreachable with the default ACC_W but required for larger values.
REQ-023 outVal and outValid SHALL stay stable while outValid=1 and outReady=0.
REQ-024 The accumulator SHALL clear on the OUT->IDLE transition, so there is no carry-over between sums.

Reset
REQ-025 rst=1 at any clock edge SHALL force state IDLE, accumulator and product register 0, outValid 0 and outVal 0x0000, aborting any partial sum.
REQ-026 inReady SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With NEURON_BIAS_EN defined, the block SHALL have an input inBias (16-bit signed Q4.12), sampled with the first term of each sum and preloaded into the accumulator as inBias<<12.
REQ-028 Without NEURON_BIAS_EN, the inBias port SHALL be absent and the accumulator SHALL start each sum at zero.

Structure
REQ-029 A shared package neuron_pkg SHALL hold ACC_W, FRAC_BITS, FP16_BIAS=15, FP16_ONE=16'h3c00, FP16_MAXF=16'h7bff and the state encoding.
REQ-030 The fixed-to-half conversion (leading-one detect plus pack) SHALL be a combinational sub-module mod_fix2half, instantiated once and registered in CONV.

Verification
REQ-031 One term 0x1000*0x1000 with inLast -> outVal 0x3c00 at t+3.
REQ-032 Terms 0x1000*0x1000 then 0x0800*0x1000 (last) -> 0x3e00 (1.5); 0xF000*0x2000 -> 0xc000 (-2.0).
REQ-033 0x0001*0x0001 -> 0x0000 (underflow flush); 0x1000*0x1000 plus 0xF000*0x1000 -> 0x0000 (exact zero).
REQ-034 outReady held low 5 cycles in OUT -> outVal stable, inReady=0, no term accepted; release -> IDLE, next sum independent of the previous one.
REQ-035 rst pulsed after 2 of 4 terms -> outValid stays 0; a fresh sum 0x1000*0x1000 -> 0x3c00.
REQ-036 With NEURON_BIAS_EN, inBias=0x1000 plus term 0x1000*0x1000 -> 0x4000 (2.0).

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the neuron accumulator and its FP16 converter.
package neuron_pkg;

   localparam int unsigned ACC_W     = 40;
   localparam int unsigned FRAC_BITS = 24;
   localparam int unsigned OPND_FRAC = 12;
   localparam int unsigned FP16_BIAS = 15;
   localparam logic [15:0] FP16_ONE  = 16'h3c00;
   localparam logic [15:0] FP16_MAXF = 16'h7bff;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACCUM = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CONV  = 3'd3,
      ST_OUT   = 3'd4
   } state_e;

endpackage

// File: rtl/mod_fix2half.sv
// Combinational signed fixed-point (Q.FRAC_BITS) to IEEE half conversion.
// Truncates toward zero, flushes denormals to zero, clamps overflow to max finite.
module mod_fix2half #(
   parameter int unsigned ACC_W     = neuron_pkg::ACC_W,
   parameter int unsigned FRAC_BITS = neuron_pkg::FRAC_BITS
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic [15:0]             half_o
);
   import neuron_pkg::*;

   logic             sign;
   logic [ACC_W-1:0] mag;
   int               msb;
   int               exp_v;
   int unsigned      sh;
   logic [9:0]       mant;

   always_comb begin
      sign  = acc_i[ACC_W-1];
      mag   = sign ? (~acc_i + ACC_W'(1)) : acc_i;
      // leading-one detect; msb stays -1 for a zero magnitude
      msb   = -1;
      for (int i = 0; i < int'(ACC_W); i++) begin
         if (mag[i]) msb = i;
      end
      exp_v = msb - int'(FRAC_BITS) + int'(FP16_BIAS);
      sh    = (msb > 10) ? unsigned'(msb - 10) : 0;
      mant  = 10'(mag >> sh);
      if (msb < 0 || exp_v <= 0) begin
         half_o = 16'h0000;
      end else if (exp_v >= 31) begin
         half_o = {sign, FP16_MAXF[14:0]};
      end else begin
         half_o = {sign, 5'(exp_v), mant};
      end
   end

endmodule

// File: rtl/mod_neuron_acc.sv
// Neuron MAC: Q4.12 x Q4.12 products summed into a saturating accumulator, emitted as FP16.
// Define NEURON_BIAS_EN to add the inBias port, preloaded with the first term of each sum.
module mod_neuron_acc #(
   parameter int unsigned ACC_W     = neuron_pkg::ACC_W,
   parameter int unsigned FRAC_BITS = neuron_pkg::FRAC_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inValid,
   output logic               inReady,
   input  logic signed [15:0] inWeight,
   input  logic signed [15:0] inAct,
   input  logic               inLast,
`ifdef NEURON_BIAS_EN
   input  logic signed [15:0] inBias,
`endif
   output logic               outValid,
   input  logic               outReady,
   output logic [15:0]        outVal
);
   import neuron_pkg::*;

   localparam int unsigned PROD_W = 32;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sat;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     prod_vld_q, prod_vld_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic [15:0]              out_val_q, out_val_d;
   logic [15:0]              half;
   logic signed [SUM_W-1:0]  sum;
   logic                     accept;

   mod_fix2half #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_fix2half (
      .acc_i  (acc_q),
      .half_o (half)
   );

   // one guard bit detects overflow; clamp is symmetric around zero
   always_comb begin
      sum = SUM_W'(acc_q) + SUM_W'(prod_q);
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
         acc_sat = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sat = ACC_W'(sum);
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      prod_d      = prod_q;
      prod_vld_d  = 1'b0;
      out_valid_d = out_valid_q;
      out_val_d   = out_val_q;
      accept      = inValid && in_ready_q;

      if (prod_vld_q) acc_d = acc_sat;
      if (accept) begin
         prod_d     = PROD_W'(inWeight) * PROD_W'(inAct);
         prod_vld_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = inLast ? ST_DRAIN : ST_ACCUM;
`ifdef NEURON_BIAS_EN
               acc_d   = ACC_W'(inBias) <<< (FRAC_BITS - OPND_FRAC);
`endif
            end
         end
         ST_ACCUM: begin
            if (accept && inLast) state_d = ST_DRAIN;
         end
         // last product lands in the accumulator on this edge
         ST_DRAIN: state_d = ST_CONV;
         ST_CONV: begin
            out_val_d   = half;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (outReady) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_val_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_val_q   <= out_val_d;
      end
   end

   assign inReady  = in_ready_q;
   assign outValid = out_valid_q;
   assign outVal   = out_val_q;

endmodule

// File: tb/tb_mod_neuron_acc.sv
// Directed self-checking bench for mod_neuron_acc; bias case runs only with NEURON_BIAS_EN.
module tb_mod_neuron_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [15:0] inWeight = '0;
   logic [15:0] inAct = '0;
   logic        inLast = 1'b0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [15:0] outVal;
`ifdef NEURON_BIAS_EN
   logic [15:0] inBias = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mod_neuron_acc dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .inWeight (inWeight),
      .inAct    (inAct),
      .inLast   (inLast),
`ifdef NEURON_BIAS_EN
      .inBias   (inBias),
`endif
      .outValid (outValid),
      .outReady (outReady),
      .outVal   (outVal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic term(input logic [15:0] w, input logic [15:0] a, input logic last);
      check("in_ready_before_term", 16'(inReady), 16'h0001);
      inValid  = 1'b1;
      inWeight = w;
      inAct    = a;
      inLast   = last;
      tick();
      inValid  = 1'b0;
      inLast   = 1'b0;
   endtask

   task automatic burst(input logic [15:0] w, input logic [15:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         inValid  = 1'b1;
         inWeight = w;
         inAct    = a;
         inLast   = (i == n - 1);
         tick();
      end
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   // Called just after the edge that accepted the last term (cycle t+1).
   task automatic expect_out(input string tag, input logic [15:0] exp);
      check({tag, "_valid_t1"}, 16'(outValid), 16'h0000);
      tick();
      check({tag, "_valid_t2"}, 16'(outValid), 16'h0000);
      tick();
      check({tag, "_valid_t3"}, 16'(outValid), 16'h0001);
      check({tag, "_val"}, outVal, exp);
      check({tag, "_ready_in_out"}, 16'(inReady), 16'h0000);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      check({tag, "_valid_after_pop"}, 16'(outValid), 16'h0000);
      check({tag, "_ready_after_pop"}, 16'(inReady), 16'h0001);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      check("reset_out_valid", 16'(outValid), 16'h0000);
      check("reset_out_val", outVal, 16'h0000);
      rst = 1'b0;
      tick();
      check("ready_after_reset", 16'(inReady), 16'h0001);

      // single-term sum: 1.0 * 1.0
      term(16'h1000, 16'h1000, 1'b1);
      expect_out("one_term", 16'h3c00);

      // 1.0 + 0.5
      term(16'h1000, 16'h1000, 1'b0);
      term(16'h0800, 16'h1000, 1'b1);
      expect_out("sum_1p5", 16'h3e00);

      // -1.0 * 2.0
      term(16'hF000, 16'h2000, 1'b1);
      expect_out("neg_2", 16'hc000);

      // 2^-24 underflows to zero
      term(16'h0001, 16'h0001, 1'b1);
      expect_out("underflow", 16'h0000);

      // 1.0 - 1.0 is exactly zero
      term(16'h1000, 16'h1000, 1'b0);
      term(16'hF000, 16'h1000, 1'b1);
      expect_out("exact_zero", 16'h0000);

      // 4.0 + 0.5 with idle cycles between terms
      term(16'h2000, 16'h2000, 1'b0);
      tick();
      tick();
      term(16'h1000, 16'h0800, 1'b1);
      expect_out("gap_4p5", 16'h4480);

      // 520 x 2^30 exceeds 2^39: positive clamp
      burst(16'h8000, 16'h8000, 520);
      expect_out("sat_pos", 16'h77ff);

      // 520 x (-32768*32767): negative clamp
      burst(16'h8000, 16'h7fff, 520);
      expect_out("sat_neg", 16'hf7ff);

      // backpressure: 3.0 held for 5 cycles while terms are offered
      term(16'h3000, 16'h1000, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         inValid  = 1'b1;
         inWeight = 16'h7000;
         inAct    = 16'h7000;
         inLast   = 1'b1;
         check("bp_valid", 16'(outValid), 16'h0001);
         check("bp_val", outVal, 16'h4200);
         check("bp_ready", 16'(inReady), 16'h0000);
         tick();
      end
      inValid = 1'b0;
      inLast  = 1'b0;
      check("bp_val_end", outVal, 16'h4200);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      check("bp_pop_valid", 16'(outValid), 16'h0000);
      term(16'h1000, 16'h1000, 1'b1);
      expect_out("after_bp", 16'h3c00);

      // reset in the middle of a 4-term sum
      term(16'h1000, 16'h1000, 1'b0);
      term(16'h1000, 16'h1000, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_val", outVal, 16'h0000);
      check("midrst_ready", 16'(inReady), 16'h0001);
      for (int i = 0; i < 4; i++) begin
         check("midrst_no_valid", 16'(outValid), 16'h0000);
         tick();
      end
      term(16'h1000, 16'h1000, 1'b1);
      expect_out("after_rst", 16'h3c00);

`ifdef NEURON_BIAS_EN
      // bias 1.0 + 1.0 * 1.0
      inBias = 16'h1000;
      term(16'h1000, 16'h1000, 1'b1);
      inBias = 16'h0000;
      expect_out("bias", 16'h4000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
